// File: rtl/dendy_bus.sv
// rtl/dendy_bus.sv - Dendy CPU bus decoder, joypad ports and OAM DMA engine
module dendy_bus #(
  parameter bit         PRG_16K   = 1'b0,
  parameter logic [7:0] OPEN_INIT = 8'hFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce_in,
  output logic        cpu_ce,
  input  logic [15:0] cpu_A,
  input  logic [7:0]  cpu_D,
  input  logic        cpu_R,
  input  logic        cpu_W,
  output logic [7:0]  cpu_I,
  output logic [10:0] ram_a,
  output logic [7:0]  ram_d,
  output logic        ram_we,
  input  logic [7:0]  ram_q,
  output logic [2:0]  ppu_a,
  output logic [7:0]  ppu_d,
  output logic        ppu_we,
  output logic        ppu_rd,
  input  logic [7:0]  ppu_q,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_d,
  output logic        oam_we,
  output logic [14:0] prg_a,
  input  logic [7:0]  prg_q,
  input  logic [7:0]  joy1,
  input  logic [7:0]  joy2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_RD,
    S_WR
  } dma_state_t;

  dma_state_t  state;
  dma_state_t  state_next;
  logic        dma_busy;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  dma_data;
  logic        parity;
  logic [7:0]  open_bus;
  logic        strobe;
  logic [7:0]  sh1;
  logic [7:0]  sh2;
  logic [15:0] bus_a;
  logic        sel_ram;
  logic        sel_ppu;
  logic        sel_prg;
  logic        sel_j1;
  logic        sel_j2;
  logic        sel_dma;
  logic        commit;
  logic        cpu_rd;
  logic        cpu_wr;

  // While the DMA engine owns the bus the CPU is frozen and its requests are dropped.
  assign dma_busy = (state != S_IDLE);
  assign cpu_ce   = ce_in & ~dma_busy;
  assign bus_a    = dma_busy ? {page, idx} : cpu_A;
  assign commit   = reset_n & ce_in & ~dma_busy;
  assign cpu_rd   = commit & cpu_R;
  assign cpu_wr   = commit & cpu_W;

  // Address decode of whichever master currently drives the bus.
  always_comb begin
    sel_ram = (bus_a[15:13] == 3'b000);
    sel_ppu = (bus_a[15:13] == 3'b001);
    sel_prg = bus_a[15];
    sel_j1  = (bus_a == 16'h4016);
    sel_j2  = (bus_a == 16'h4017);
    sel_dma = (bus_a == 16'h4014);
  end

  assign ram_a  = bus_a[10:0];
  assign ram_d  = cpu_D;
  assign ram_we = cpu_wr & sel_ram;
  assign ppu_a  = bus_a[2:0];
  assign ppu_d  = cpu_D;
  assign ppu_we = cpu_wr & sel_ppu;
  assign ppu_rd = cpu_rd & sel_ppu;
  assign prg_a  = PRG_16K ? {1'b0, bus_a[13:0]} : bus_a[14:0];
  assign oam_a  = idx;
  assign oam_d  = dma_data;
  assign oam_we = reset_n & ce_in & (state == S_WR);

  // Read data mux; registers with side effects are invisible to DMA and read as open bus.
  always_comb begin
    cpu_I = open_bus;
    if (sel_ram) begin
      cpu_I = ram_q;
    end else if (sel_prg) begin
      cpu_I = prg_q;
    end else if (sel_ppu && !dma_busy) begin
      cpu_I = ppu_q;
    end else if (sel_j1 && !dma_busy) begin
      cpu_I = {7'b0100000, sh1[0]};
    end else if (sel_j2 && !dma_busy) begin
      cpu_I = {7'b0100000, sh2[0]};
    end
  end

  // Open-bus latch remembers the last value the CPU actually read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      open_bus <= OPEN_INIT;
    end else if (cpu_rd) begin
      open_bus <= cpu_I;
    end
  end

  // Joypad strobe and shift registers; ones shift in so reads past bit 8 return 1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      strobe <= 1'b0;
      sh1    <= 8'h00;
      sh2    <= 8'h00;
    end else begin
      if (cpu_wr && sel_j1) begin
        strobe <= cpu_D[0];
      end
      if (strobe) begin
        sh1 <= joy1;
        sh2 <= joy2;
      end else begin
        if (cpu_rd && sel_j1) begin
          sh1 <= {1'b1, sh1[7:1]};
        end
        if (cpu_rd && sel_j2) begin
          sh2 <= {1'b1, sh2[7:1]};
        end
      end
    end
  end

  // DMA datapath: tick parity, source page, byte index and the byte in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      parity   <= 1'b0;
      page     <= 8'h00;
      idx      <= 8'h00;
      dma_data <= 8'h00;
    end else begin
      if (ce_in) begin
        parity <= ~parity;
      end
      if (cpu_wr && sel_dma) begin
        page <= cpu_D;
        idx  <= 8'h00;
      end
      if (ce_in && (state == S_RD)) begin
        dma_data <= cpu_I;
      end
      if (ce_in && (state == S_WR)) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // DMA state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DMA next state: align to an odd tick, then 256 read/write pairs.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cpu_wr && sel_dma) state_next = S_ALIGN;
      S_ALIGN: if (ce_in && parity) state_next = S_RD;
      S_RD:    if (ce_in) state_next = S_WR;
      S_WR:    if (ce_in) state_next = (idx == 8'hFF) ? S_IDLE : S_RD;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dendy_bus.sv
// tb/tb_dendy_bus.sv - scoreboard testbench for dendy_bus
module tb_dendy_bus;
  logic        clock;
  logic        reset_n;
  logic        ce_in;
  logic [15:0] cpu_A;
  logic [7:0]  cpu_D;
  logic        cpu_R;
  logic        cpu_W;
  logic [7:0]  ram_q;
  logic [7:0]  ppu_q;
  logic [7:0]  prg_q;
  logic [7:0]  joy1;
  logic [7:0]  joy2;

  logic        cpu_ce;
  logic [7:0]  cpu_I;
  logic [10:0] ram_a;
  logic [7:0]  ram_d;
  logic        ram_we;
  logic [2:0]  ppu_a;
  logic [7:0]  ppu_d;
  logic        ppu_we;
  logic        ppu_rd;
  logic [7:0]  oam_a;
  logic [7:0]  oam_d;
  logic        oam_we;
  logic [14:0] prg_a;

  logic        u1_cpu_ce;
  logic [7:0]  u1_cpu_I;
  logic [10:0] u1_ram_a;
  logic [7:0]  u1_ram_d;
  logic        u1_ram_we;
  logic [2:0]  u1_ppu_a;
  logic [7:0]  u1_ppu_d;
  logic        u1_ppu_we;
  logic        u1_ppu_rd;
  logic [7:0]  u1_oam_a;
  logic [7:0]  u1_oam_d;
  logic        u1_oam_we;
  logic [14:0] u1_prg_a;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;

  logic [7:0]  ram_mem [0:2047];
  logic [15:0] oam_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] mon_exp;

  logic [7:0]  s_I;
  logic        s_ram_we;
  logic [10:0] s_ram_a;
  logic [7:0]  s_ram_d;
  logic        s_ppu_we;
  logic        s_ppu_rd;
  logic [2:0]  s_ppu_a;
  logic [7:0]  s_ppu_d;
  logic [14:0] s_prg_a;
  logic [14:0] s_prg_a1;
  int          s_tick;

  dendy_bus #(.PRG_16K(1'b0), .OPEN_INIT(8'hFF)) dut (
    .clock(clock), .reset_n(reset_n), .ce_in(ce_in), .cpu_ce(cpu_ce),
    .cpu_A(cpu_A), .cpu_D(cpu_D), .cpu_R(cpu_R), .cpu_W(cpu_W), .cpu_I(cpu_I),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .ppu_a(ppu_a), .ppu_d(ppu_d), .ppu_we(ppu_we), .ppu_rd(ppu_rd), .ppu_q(ppu_q),
    .oam_a(oam_a), .oam_d(oam_d), .oam_we(oam_we),
    .prg_a(prg_a), .prg_q(prg_q), .joy1(joy1), .joy2(joy2)
  );

  dendy_bus #(.PRG_16K(1'b1), .OPEN_INIT(8'hFF)) dut16 (
    .clock(clock), .reset_n(reset_n), .ce_in(ce_in), .cpu_ce(u1_cpu_ce),
    .cpu_A(cpu_A), .cpu_D(cpu_D), .cpu_R(cpu_R), .cpu_W(cpu_W), .cpu_I(u1_cpu_I),
    .ram_a(u1_ram_a), .ram_d(u1_ram_d), .ram_we(u1_ram_we), .ram_q(ram_q),
    .ppu_a(u1_ppu_a), .ppu_d(u1_ppu_d), .ppu_we(u1_ppu_we), .ppu_rd(u1_ppu_rd), .ppu_q(ppu_q),
    .oam_a(u1_oam_a), .oam_d(u1_oam_d), .oam_we(u1_oam_we),
    .prg_a(u1_prg_a), .prg_q(prg_q), .joy1(joy1), .joy2(joy2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // CPU tick strobe: one clock high, one clock low.
  initial begin
    ce_in = 1'b0;
    forever begin
      @(posedge clock);
      #1 ce_in = ~ce_in;
    end
  end

  // Synchronous memory models behind the bus.
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_a] <= ram_d;
    ram_q <= ram_mem[ram_a];
    ppu_q <= {5'b10100, ppu_a};
    prg_q <= prg_a[7:0] ^ {1'b0, prg_a[14:8]};
  end

  // Count CPU ticks since reset release to predict DMA alignment.
  always @(posedge clock) begin
    if (!reset_n) tick_cnt = 0;
    else if (ce_in) tick_cnt = tick_cnt + 1;
  end

  // OAM write monitor: every oam_we must match the front of the scoreboard.
  always @(negedge clock) begin
    if (oam_we === 1'b1) begin
      checks++;
      if (oam_q.size() == 0) begin
        errors++;
        $display("FAIL oam_unexpected: got oam_we=1 oam_a=%h oam_d=%h, required no write", oam_a, oam_d);
      end else begin
        mon_exp = oam_q.pop_front();
        if ({oam_a, oam_d} !== mon_exp) begin
          errors++;
          $display("FAIL oam_write: got a=%h d=%h, required a=%h d=%h",
                   oam_a, oam_d, mon_exp[15:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic bus_op(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
    cpu_A = a;
    cpu_D = d;
    cpu_W = w;
    cpu_R = r;
    @(posedge clock);
    @(negedge clock);
    s_I      = cpu_I;
    s_ram_we = ram_we;
    s_ram_a  = ram_a;
    s_ram_d  = ram_d;
    s_ppu_we = ppu_we;
    s_ppu_rd = ppu_rd;
    s_ppu_a  = ppu_a;
    s_ppu_d  = ppu_d;
    s_prg_a  = prg_a;
    s_prg_a1 = u1_prg_a;
    s_tick   = tick_cnt;
    @(posedge clock);
    #2;
    cpu_W = 1'b0;
    cpu_R = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input string name);
    logic [7:0] x;
    rd_q.push_back(e);
    bus_op(1'b0, 1'b1, a, 8'h00);
    x = rd_q.pop_front();
    checks++;
    if (s_I !== x) begin
      errors++;
      $display("FAIL %s: got cpu_I=%h, required %h", name, s_I, x);
    end
  endtask

  task automatic idle_tick();
    @(posedge clock);
    @(posedge clock);
    #2;
  endtask

  task automatic sync_commit();
    do @(posedge clock); while (ce_in !== 1'b1);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_A = 16'h0000; cpu_D = 8'h00; cpu_W = 1'b1; cpu_R = 1'b1;
    joy1 = 8'h00; joy2 = 8'h00;
    repeat (3) @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (cpu_ce !== ce_in || ram_we !== 1'b0 || oam_we !== 1'b0 || ppu_rd !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got cpu_ce=%b ce_in=%b ram_we=%b oam_we=%b ppu_rd=%b, required cpu_ce=ce_in and pulses 0",
                 cpu_ce, ce_in, ram_we, oam_we, ppu_rd);
      end
    end
    cpu_W = 1'b0; cpu_R = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    sync_commit();
    bus_read(16'h4000, 8'hFF, "reset_open_bus");
    bus_read(16'h4016, 8'h40, "reset_joy_zero");
  endtask

  task automatic test_ram();
    bus_op(1'b1, 1'b0, 16'h0005, 8'h3C);
    checks++;
    if (s_ram_we !== 1'b1 || s_ram_a !== 11'h005 || s_ram_d !== 8'h3C) begin
      errors++;
      $display("FAIL ram_write: got we=%b a=%h d=%h, required we=1 a=005 d=3c", s_ram_we, s_ram_a, s_ram_d);
    end
    bus_read(16'h0805, 8'h3C, "ram_mirror_read");
    checks++;
    if (s_ram_a !== 11'h005 || s_ram_we !== 1'b0) begin
      errors++;
      $display("FAIL ram_mirror_addr: got a=%h we=%b, required a=005 we=0", s_ram_a, s_ram_we);
    end
    bus_op(1'b0, 1'b1, 16'h1FFD, 8'h00);
    checks++;
    if (s_ram_a !== 11'h7FD) begin
      errors++;
      $display("FAIL ram_top_addr: got a=%h, required 7fd", s_ram_a);
    end
  endtask

  task automatic test_ppu();
    bus_op(1'b1, 1'b0, 16'h2006, 8'h21);
    checks++;
    if (s_ppu_we !== 1'b1 || s_ppu_a !== 3'd6 || s_ppu_d !== 8'h21 || s_ppu_rd !== 1'b0) begin
      errors++;
      $display("FAIL ppu_write: got we=%b a=%0d d=%h rd=%b, required we=1 a=6 d=21 rd=0",
               s_ppu_we, s_ppu_a, s_ppu_d, s_ppu_rd);
    end
    bus_read(16'h3FFA, 8'hA2, "ppu_read_data");
    checks++;
    if (s_ppu_rd !== 1'b1 || s_ppu_a !== 3'd2 || s_ppu_we !== 1'b0) begin
      errors++;
      $display("FAIL ppu_read: got rd=%b a=%0d we=%b, required rd=1 a=2 we=0", s_ppu_rd, s_ppu_a, s_ppu_we);
    end
    @(negedge clock);
    checks++;
    if (ppu_rd !== 1'b0) begin
      errors++;
      $display("FAIL ppu_rd_width: got ppu_rd=%b after commit, required 0", ppu_rd);
    end
    sync_commit();
  endtask

  task automatic test_joypad();
    logic b;
    joy1 = 8'b1000_0101;
    joy2 = 8'h00;
    bus_op(1'b1, 1'b0, 16'h4016, 8'h01);
    idle_tick();
    bus_op(1'b1, 1'b0, 16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) begin
      b = (i < 8) ? joy1[i] : 1'b1;
      bus_read(16'h4016, {7'b0100000, b}, $sformatf("joy1_bit%0d", i));
    end
  endtask

  task automatic run_dma(input int want_parity, input string name);
    int stall;
    int exp_stall;
    int budget;
    if ((tick_cnt % 2) != want_parity) idle_tick();
    for (int i = 0; i < 256; i++) oam_q.push_back({i[7:0], i[7:0] ^ 8'hA5});
    bus_op(1'b1, 1'b0, 16'h4014, 8'h02);
    exp_stall = ((s_tick % 2) == 0) ? 513 : 514;
    stall = 0;
    budget = 0;
    forever begin
      @(negedge clock);
      budget++;
      if (budget > 3000) break;
      if (ce_in) begin
        if (cpu_ce) break;
        stall++;
      end
    end
    checks++;
    if (stall != exp_stall) begin
      errors++;
      $display("FAIL %s_stall: got %0d stalled ticks, required %0d", name, stall, exp_stall);
    end
    checks++;
    if (oam_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: got %0d writes missing, required 0", name, oam_q.size());
    end
    @(posedge clock);
    #2;
  endtask

  task automatic test_dma();
    for (int i = 0; i < 256; i++) bus_op(1'b1, 1'b0, 16'h0200 + 16'(i), i[7:0] ^ 8'hA5);
    run_dma(0, "dma_even");
    run_dma(1, "dma_odd");
  endtask

  task automatic test_prg_open_bus();
    bus_read(16'hC123, 8'h62, "prg_read_data");
    checks++;
    if (s_prg_a !== 15'h4123 || s_prg_a1 !== 15'h0123) begin
      errors++;
      $display("FAIL prg_addr: got 32k=%h 16k=%h, required 4123 and 0123", s_prg_a, s_prg_a1);
    end
    bus_op(1'b1, 1'b0, 16'h0010, 8'h77);
    bus_read(16'h0010, 8'h77, "ram_read_77");
    bus_read(16'h5000, 8'h77, "open_bus_5000");
  endtask

  task automatic test_reset_mid_dma();
    int budget;
    int seen;
    for (int i = 0; i < 256; i++) oam_q.push_back({i[7:0], i[7:0] ^ 8'hA5});
    bus_op(1'b1, 1'b0, 16'h4014, 8'h02);
    budget = 0;
    while (oam_q.size() > 216 && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    if (oam_q.size() != 216) begin
      errors++;
      $display("FAIL dma_reach_idx40: got %0d pending, required 216", oam_q.size());
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    oam_q.delete();
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (cpu_ce !== ce_in) begin
        errors++;
        $display("FAIL reset_mid_dma_ce: got cpu_ce=%b ce_in=%b, required equal", cpu_ce, ce_in);
      end
    end
    @(posedge clock);
    #2 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (oam_we === 1'b1) seen++;
      if (ce_in && cpu_ce !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_dma_abort: got %0d oam writes or stalls, required 0", seen);
    end
    sync_commit();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_ppu();
    test_joypad();
    test_dma();
    test_prg_open_bus();
    test_reset_mid_dma();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
